branch_predictor: RTL and testbench

Front-end branch predictor that supplies the predicted direction and target that later travel with each control-flow instruction to the execute-stage branch unit. The block holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry. Fetch lookups are combinational. Resolved outcomes returned from execute train the tables on the next clock edge.

---
 rtl/branch_predictor.sv | 188 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//
// Front-end branch predictor: a direct-mapped branch target buffer (BTB) with
// a 2-bit saturating direction counter per entry. Fetch lookups are purely
// combinational. Resolved outcomes from execute train the table on the next
// rising clock edge. Lookup and update use independent ports. A lookup that
// hits the entry being updated in the same cycle sees the pre-update contents.
//
// Parameters
//   DATA_WIDTH   PC / target width
//   BTB_ENTRIES  number of BTB entries (power of two, >= 2)
//   IDX_W        log2(BTB_ENTRIES)
//   TAG_W        stored tag width (DATA_WIDTH - IDX_W - 2)
//
// Ports
//   i_clk                 clock, all state changes on the rising edge
//   i_rst                 asynchronous active-high reset
//   i_fetch_valid         fetch PC valid this cycle
//   i_fetch_pc            PC being fetched
//   o_pred_taken          predicted taken for i_fetch_pc
//   o_pred_target         predicted next PC (target if taken, else pc+4)
//   i_resolve_valid       resolved control-flow instruction presented
//   i_resolve_pc          PC of the resolved instruction
//   i_resolve_is_branch   1 = conditional branch, 0 = JAL/JALR
//   i_resolve_taken       actual outcome
//   i_resolve_target      actual taken target
//   i_resolve_mispredict  execute flagged a misprediction (statistics only)
//   o_stat_resolved       resolved-instruction count
//   o_stat_mispredicts    misprediction count
//
// Optional feature macro: BRANCH_PREDICTOR_STATS_EN
//   Defined     : saturating 32-bit resolve / mispredict counters are built.
//   Not defined : no counters; both statistics outputs read 0.
// ----------------------------------------------------------------------------
module branch_predictor #(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES),
    parameter int TAG_W       = DATA_WIDTH - IDX_W - 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fetch_valid,
    input  logic [DATA_WIDTH-1:0] i_fetch_pc,
    output logic                  o_pred_taken,
    output logic [DATA_WIDTH-1:0] o_pred_target,
    input  logic                  i_resolve_valid,
    input  logic [DATA_WIDTH-1:0] i_resolve_pc,
    input  logic                  i_resolve_is_branch,
    input  logic                  i_resolve_taken,
    input  logic [DATA_WIDTH-1:0] i_resolve_target,
    input  logic                  i_resolve_mispredict,
    output logic [31:0]           o_stat_resolved,
    output logic [31:0]           o_stat_mispredicts
);

    // Direction counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Flattened views of the per-entry state, used by both lookup ports
    logic [BTB_ENTRIES-1:0] valid_vec;
    logic [BTB_ENTRIES-1:0] uncond_vec;
    logic [1:0]             ctr_arr    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_arr    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  target_arr [BTB_ENTRIES];

    // ------------------------------------------------------------------
    // Fetch lookup (combinational)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;
    logic             fetch_taken;

    assign fetch_idx   = i_fetch_pc[IDX_W+1:2];
    assign fetch_tag   = i_fetch_pc[DATA_WIDTH-1:IDX_W+2];
    assign fetch_hit   = valid_vec[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
    // Jumps are always predicted taken; branches follow the counter MSB.
    assign fetch_taken = i_fetch_valid && fetch_hit &&
                         (uncond_vec[fetch_idx] || ctr_arr[fetch_idx][1]);

    assign o_pred_taken  = fetch_taken;
    assign o_pred_target = fetch_taken ? target_arr[fetch_idx]
                                       : i_fetch_pc + DATA_WIDTH'(4);

    // ------------------------------------------------------------------
    // Resolve lookup (determines hit / allocate for training)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;

    assign res_idx = i_resolve_pc[IDX_W+1:2];
    assign res_tag = i_resolve_pc[DATA_WIDTH-1:IDX_W+2];
    // An invalid entry never counts as a hit, so stale tags cannot be trained.
    assign res_hit = valid_vec[res_idx] && (tag_arr[res_idx] == res_tag);

    // ------------------------------------------------------------------
    // Per-entry storage and training
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
        logic                  valid_reg;
        logic                  uncond_reg;
        logic [1:0]            ctr_reg;
        logic [TAG_W-1:0]      tag_reg;
        logic [DATA_WIDTH-1:0] target_reg;
        logic                  sel;

        assign sel = i_resolve_valid && (res_idx == IDX_W'(gi));

        // Valid bit and counter carry the reset state.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                valid_reg <= 1'b0;
                ctr_reg   <= CTR_WNT;
            end else if (sel) begin
                if (i_resolve_taken) begin
                    if (res_hit) begin
                        ctr_reg <= (ctr_reg == CTR_ST) ? CTR_ST : ctr_reg + 2'd1;
                    end else begin
                        valid_reg <= 1'b1;
                        ctr_reg   <= i_resolve_is_branch ? CTR_WT : CTR_ST;
                    end
                end else if (res_hit) begin
                    ctr_reg <= (ctr_reg == CTR_SNT) ? CTR_SNT : ctr_reg - 2'd1;
                end
            end
        end

        // Tag/target/uncond are don't-care until the entry is valid, so they
        // need no reset. On a taken hit the tag is unchanged, so rewriting it
        // unconditionally on every taken resolve is harmless.
        always_ff @(posedge i_clk) begin
            if (sel && i_resolve_taken) begin
                tag_reg    <= res_tag;
                target_reg <= i_resolve_target;
                uncond_reg <= !i_resolve_is_branch;
            end
        end

        assign valid_vec[gi]  = valid_reg;
        assign uncond_vec[gi] = uncond_reg;
        assign ctr_arr[gi]    = ctr_reg;
        assign tag_arr[gi]    = tag_reg;
        assign target_arr[gi] = target_reg;
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_resolved_reg;
    logic [31:0] stat_mispredicts_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stat_resolved_reg    <= 32'd0;
            stat_mispredicts_reg <= 32'd0;
        end else if (i_resolve_valid) begin
            if (stat_resolved_reg != 32'hFFFF_FFFF) begin
                stat_resolved_reg <= stat_resolved_reg + 32'd1;
            end
            if (i_resolve_mispredict && (stat_mispredicts_reg != 32'hFFFF_FFFF)) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign o_stat_resolved    = stat_resolved_reg;
    assign o_stat_mispredicts = stat_mispredicts_reg;

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_bits;
    assign unused_bits = ^{i_fetch_pc[1:0], i_resolve_pc[1:0]};
`else
    assign o_stat_resolved    = 32'd0;
    assign o_stat_mispredicts = 32'd0;

    // Byte-offset bits and the mispredict flag have no consumer in this build.
    logic unused_bits;
    assign unused_bits = ^{i_fetch_pc[1:0], i_resolve_pc[1:0], i_resolve_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor. A behavioural BTB model (plain
// arrays, integer counters) is trained at each rising edge from the resolve
// inputs; a compare process checks every DUT output against the model on each
// falling edge. Directed scenarios add hand-computed literal expectations,
// followed by a randomized phase with occasional asynchronous resets.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int N = 16;

    logic        i_clk;
    logic        i_rst;
    logic        i_fetch_valid;
    logic [31:0] i_fetch_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_resolve_valid;
    logic [31:0] i_resolve_pc;
    logic        i_resolve_is_branch;
    logic        i_resolve_taken;
    logic [31:0] i_resolve_target;
    logic        i_resolve_mispredict;
    logic [31:0] o_stat_resolved;
    logic [31:0] o_stat_mispredicts;

    branch_predictor #(.DATA_WIDTH(32), .BTB_ENTRIES(N)) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_fetch_valid       (i_fetch_valid),
        .i_fetch_pc          (i_fetch_pc),
        .o_pred_taken        (o_pred_taken),
        .o_pred_target       (o_pred_target),
        .i_resolve_valid     (i_resolve_valid),
        .i_resolve_pc        (i_resolve_pc),
        .i_resolve_is_branch (i_resolve_is_branch),
        .i_resolve_taken     (i_resolve_taken),
        .i_resolve_target    (i_resolve_target),
        .i_resolve_mispredict(i_resolve_mispredict),
        .o_stat_resolved     (o_stat_resolved),
        .o_stat_mispredicts  (o_stat_mispredicts)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 0;
    int cyc_no = 0;

    // ---------------- behavioural model ----------------
    bit          m_valid  [N];
    logic [31:0] m_line   [N];   // pc >> 6 of the owning instruction
    logic [31:0] m_target [N];
    bit          m_uncond [N];
    int          m_ctr    [N];   // 0..3, >= 2 predicts taken
    longint      m_res;
    longint      m_mis;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_res = 0;
        m_mis = 0;
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && (m_line[i] == (pc >> 6));
    endfunction

    always @(posedge i_rst) model_clear();

    always @(posedge i_clk) begin
        if (run && !i_rst && i_resolve_valid) begin
            int  i;
            bit  h;
            i = idx_of(i_resolve_pc);
            h = model_hit(i_resolve_pc);
            if (i_resolve_taken) begin
                if (h) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                end else begin
                    m_valid[i] = 1;
                    m_line[i]  = i_resolve_pc >> 6;
                    m_ctr[i]   = i_resolve_is_branch ? 2 : 3;
                end
                m_target[i] = i_resolve_target;
                m_uncond[i] = !i_resolve_is_branch;
            end else if (h) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
            if (m_res < 64'hFFFF_FFFF) m_res++;
            if (i_resolve_mispredict && m_mis < 64'hFFFF_FFFF) m_mis++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge i_clk) begin
        if (run) begin
            bit          e_taken;
            logic [31:0] e_target;
            int          i;
            i        = idx_of(i_fetch_pc);
            e_taken  = i_fetch_valid && model_hit(i_fetch_pc) &&
                       (m_uncond[i] || m_ctr[i] >= 2);
            e_target = e_taken ? m_target[i] : i_fetch_pc + 32'd4;
            check("pred_taken", {31'd0, o_pred_taken}, {31'd0, e_taken});
            check("pred_target", o_pred_target, e_target);
`ifdef BRANCH_PREDICTOR_STATS_EN
            check("stat_resolved", o_stat_resolved, m_res[31:0]);
            check("stat_mispredicts", o_stat_mispredicts, m_mis[31:0]);
`else
            check("stat_resolved", o_stat_resolved, 32'd0);
            check("stat_mispredicts", o_stat_mispredicts, 32'd0);
`endif
        end
    end

    // ---------------- driver ----------------
    // Inputs change 2 time units after a rising edge; returns 1 unit after
    // the falling edge so callers can add literal checks before the update.
    task automatic cyc(input logic rst, input logic fv, input logic [31:0] fpc,
                       input logic rv, input logic [31:0] rpc, input logic br,
                       input logic tk, input logic [31:0] tgt, input logic mp);
        @(posedge i_clk);
        #2;
        i_rst                = rst;
        i_fetch_valid        = fv;
        i_fetch_pc           = fpc;
        i_resolve_valid      = rv;
        i_resolve_pc         = rpc;
        i_resolve_is_branch  = br;
        i_resolve_taken      = tk;
        i_resolve_target     = tgt;
        i_resolve_mispredict = mp;
        run                  = 1;
        cyc_no++;
        $display("cyc %0d rst=%0b fetch=%0b/%h resolve=%0b pc=%h br=%0b tk=%0b tgt=%h mp=%0b",
                 cyc_no, rst, fv, fpc, rv, rpc, br, tk, tgt, mp);
        @(negedge i_clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        cyc(0, 1, pc, 0, 32'd0, 0, 0, 32'd0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt, input logic mp);
        cyc(0, 0, 32'd0, 1, pc, br, tk, tgt, mp);
    endtask

    task automatic expect_pred(input string name, input logic tk, input logic [31:0] tgt);
        check({name, "_taken"}, {31'd0, o_pred_taken}, {31'd0, tk});
        check({name, "_target"}, o_pred_target, tgt);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, N - 1)) << 2)
             | 32'($urandom_range(0, 3));
        return pc;
    endfunction

    initial begin
        i_rst = 1'b1;
        i_fetch_valid = 0; i_fetch_pc = 0;
        i_resolve_valid = 0; i_resolve_pc = 0; i_resolve_is_branch = 0;
        i_resolve_taken = 0; i_resolve_target = 0; i_resolve_mispredict = 0;
        model_clear();
        repeat (2) @(posedge i_clk);

        // Reset state
        cyc(1, 1, 32'h100, 0, 32'd0, 0, 0, 32'd0, 0);
        expect_pred("reset", 1'b0, 32'h104);
        check("reset_stat_res", o_stat_resolved, 32'd0);

        // Same-cycle resolve + fetch on empty table: read-before-write
        cyc(0, 1, 32'h100, 1, 32'h100, 1, 1, 32'h80, 0);
        expect_pred("rbw_same", 1'b0, 32'h104);
        fetch(32'h100);
        expect_pred("rbw_next", 1'b1, 32'h80);
        cyc(0, 1, 32'h100, 1, 32'h100, 1, 0, 32'h0, 1);   // not taken: 10 -> 01
        expect_pred("nt_same", 1'b1, 32'h80);
        fetch(32'h100);
        expect_pred("nt_after", 1'b0, 32'h104);

        // Counter saturation at 0x200
        repeat (3) resolve(32'h200, 1, 1, 32'h240, 0);  // 10, 11, 11
        resolve(32'h200, 1, 0, 32'h0, 0);               // 10
        fetch(32'h200);
        expect_pred("sat_hi", 1'b1, 32'h240);
        resolve(32'h200, 1, 0, 32'h0, 0);               // 01
        fetch(32'h200);
        expect_pred("ctr_01", 1'b0, 32'h204);
        repeat (2) resolve(32'h200, 1, 0, 32'h0, 0);    // 00, 00
        resolve(32'h200, 1, 1, 32'h240, 0);             // 01
        fetch(32'h200);
        expect_pred("sat_lo", 1'b0, 32'h204);
        resolve(32'h200, 1, 1, 32'h240, 0);             // 10
        fetch(32'h200);
        expect_pred("ctr_10", 1'b1, 32'h240);

        // JAL and aliasing eviction
        resolve(32'h300, 0, 1, 32'h1000, 0);
        fetch(32'h300);
        expect_pred("jal_hit", 1'b1, 32'h1000);
        fetch(32'h340);
        expect_pred("alias_miss", 1'b0, 32'h344);
        resolve(32'h340, 1, 0, 32'h0, 0);               // no allocation on not-taken
        fetch(32'h300);
        expect_pred("no_alloc_nt", 1'b1, 32'h1000);
        resolve(32'h340, 1, 1, 32'h2000, 0);
        fetch(32'h300);
        expect_pred("evicted", 1'b0, 32'h304);
        fetch(32'h343);                                 // pc[1:0] ignored
        expect_pred("alias_hit", 1'b1, 32'h2000);

        // fetch_valid low and pc+4 wrap
        cyc(0, 0, 32'h340, 0, 32'd0, 0, 0, 32'd0, 0);
        expect_pred("fv_low", 1'b0, 32'h344);
        fetch(32'hFFFF_FFFC);
        expect_pred("wrap", 1'b0, 32'h0);

        // Mid-stream async reset with a resolve presented during reset
        cyc(1, 1, 32'h340, 1, 32'h500, 1, 1, 32'h600, 1);
        expect_pred("mid_reset", 1'b0, 32'h344);
        fetch(32'h500);
        expect_pred("rst_discard", 1'b0, 32'h504);
        check("rst_stat_mis", o_stat_mispredicts, 32'd0);

        // Statistics: 5 resolves, 2 mispredicts
        resolve(32'h100, 1, 1, 32'h80, 1);
        resolve(32'h104, 1, 0, 32'h0, 0);
        resolve(32'h108, 0, 1, 32'h90, 1);
        resolve(32'h100, 1, 0, 32'h0, 0);
        resolve(32'h10C, 1, 1, 32'hA0, 0);
        fetch(32'h100);
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stats_res5", o_stat_resolved, 32'd5);
        check("stats_mis2", o_stat_mispredicts, 32'd2);
`else
        check("stats_res0", o_stat_resolved, 32'd0);
        check("stats_mis0", o_stat_mispredicts, 32'd0);
`endif

        // Randomized phase
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, rand_pc(),
                $urandom_range(0, 2) != 0, rand_pc(), $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        @(posedge i_clk);
        #2;
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
